// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: split x/y pixel counters, registered syncs,
// combinational blanking, line/frame strobes and a wrapping frame counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 1024,
    parameter int   H_FP      = 48,
    parameter int   H_SYNC    = 104,
    parameter int   H_BP      = 152,
    parameter int   V_ACTIVE  = 768,
    parameter int   V_FP      = 3,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   XLO_W     = 5,
    parameter int   XHI_W     = 6,
    parameter int   YLO_W     = 6,
    parameter int   YHI_W     = 4,
    parameter int   FC_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [XHI_W-1:0] x_hi,
    output logic [XLO_W-1:0] x_lo,
    output logic [YHI_W-1:0] y_hi,
    output logic [YLO_W-1:0] y_lo,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             line_pulse,
    output logic             frame_pulse,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW       = XHI_W + XLO_W;
    localparam int YW       = YHI_W + YLO_W;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // A raster that does not fit the counters must stop elaboration.
    if (H_TOTAL > 2**XW) begin : g_h_too_big
        $error("vga_timing_gen: H_TOTAL exceeds 2**(XHI_W+XLO_W)");
    end
    if (V_TOTAL > 2**YW) begin : g_v_too_big
        $error("vga_timing_gen: V_TOTAL exceeds 2**(YHI_W+YLO_W)");
    end

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_wrap;
    logic          y_wrap;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          h_blank;
    logic          v_blank;

    assign x_wrap    = (x == X_LAST);
    assign y_wrap    = (y == Y_LAST);
    assign h_in_sync = (int'(x) >= HS_START) && (int'(x) < HS_END);
    assign v_in_sync = (int'(y) >= VS_START) && (int'(y) < VS_END);

    // Power-of-two active sizes collapse the blank compare to an OR of high bits.
    if (H_ACTIVE >= 2**XW) begin : g_hb_never
        assign h_blank = 1'b0;
    end else if (H_ACTIVE > 0 && (H_ACTIVE & (H_ACTIVE - 1)) == 0) begin : g_hb_pow2
        localparam int HB_BIT = $clog2(H_ACTIVE);
        assign h_blank = |x[XW-1:HB_BIT];
    end else begin : g_hb_cmp
        assign h_blank = (int'(x) >= H_ACTIVE);
    end

    if (V_ACTIVE >= 2**YW) begin : g_vb_never
        assign v_blank = 1'b0;
    end else if (V_ACTIVE > 0 && (V_ACTIVE & (V_ACTIVE - 1)) == 0) begin : g_vb_pow2
        localparam int VB_BIT = $clog2(V_ACTIVE);
        assign v_blank = |y[YW-1:VB_BIT];
    end else begin : g_vb_cmp
        assign v_blank = (int'(y) >= V_ACTIVE);
    end

    assign blank = h_blank | v_blank;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            frame_cnt   <= '0;
            line_pulse  <= 1'b0;
            frame_pulse <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
        end else begin
            line_pulse  <= ce & x_wrap;
            frame_pulse <= ce & x_wrap & y_wrap;
            if (ce) begin
                // Syncs decode the pre-advance position, so they trail by one pixel.
                hsync <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
                vsync <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
                if (x_wrap) begin
                    x <= '0;
                    if (y_wrap) begin
                        y         <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    assign x_lo = x[XLO_W-1:0];
    assign x_hi = x[XW-1:XLO_W];
    assign y_lo = y[YLO_W-1:0];
    assign y_hi = y[YW-1:YLO_W];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster (H 8/2/3/3, V 4/1/2/1).
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [1:0] x_hi;
    logic [1:0] x_lo;
    logic [1:0] y_hi;
    logic [0:0] y_lo;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       line_pulse;
    logic       frame_pulse;
    logic [1:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1),
        .XLO_W(2), .XHI_W(2), .YLO_W(1), .YHI_W(2), .FC_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .x_hi(x_hi), .x_lo(x_lo), .y_hi(y_hi), .y_lo(y_lo),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .line_pulse(line_pulse), .frame_pulse(frame_pulse),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic apply_stimulus(input logic r, input logic c);
        rst_n = r;
        ce    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs after n enabled pixels since reset, derived from the raster geometry.
    task automatic check_all(input int n, input string where);
        int ex, ey, px, py;
        logic ehs, evs;
        ex = n % 16;
        ey = (n / 16) % 8;
        if (n == 0) begin
            ehs = 1'b1;
            evs = 1'b0;
        end else begin
            px  = (n - 1) % 16;
            py  = ((n - 1) / 16) % 8;
            ehs = (px >= 10 && px < 13) ? 1'b0 : 1'b1;
            evs = (py >= 5 && py < 7) ? 1'b1 : 1'b0;
        end
        check_output({where, " x"}, {28'd0, x_hi, x_lo}, ex);
        check_output({where, " y"}, {29'd0, y_hi, y_lo}, ey);
        check_output({where, " hsync"}, {31'd0, hsync}, {31'd0, ehs});
        check_output({where, " vsync"}, {31'd0, vsync}, {31'd0, evs});
        check_output({where, " blank"}, {31'd0, blank}, (ex >= 8 || ey >= 4) ? 1 : 0);
        check_output({where, " frame_cnt"}, {30'd0, frame_cnt}, (n / 128) % 4);
    endtask

    initial begin
        int n;
        int lp_cnt, fp_cnt, hs_cnt;
        logic [3:0] x_prev;

        rst_n = 1'b0;
        ce    = 1'b0;
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        check_all(0, "reset");
        check_output("reset line_pulse", {31'd0, line_pulse}, 0);
        check_output("reset frame_pulse", {31'd0, frame_pulse}, 0);

        // Free-running for four frames.
        lp_cnt = 0;
        fp_cnt = 0;
        hs_cnt = 0;
        for (int i = 1; i <= 512; i++) begin
            apply_stimulus(1'b1, 1'b1);
            check_all(i, "run");
            check_output("run line_pulse", {31'd0, line_pulse}, (i % 16 == 0) ? 1 : 0);
            check_output("run frame_pulse", {31'd0, frame_pulse}, (i % 128 == 0) ? 1 : 0);
            if (line_pulse) lp_cnt++;
            if (frame_pulse) fp_cnt++;
            if (i <= 16 && hsync == 1'b0) hs_cnt++;
            if (i == 4) check_output("x_lo rolls", {30'd0, x_lo}, 0);
            if (i == 4) check_output("x_hi steps", {30'd0, x_hi}, 1);
        end
        check_output("hsync width first line", hs_cnt, 3);
        check_output("line_pulse count", lp_cnt, 32);
        check_output("frame_pulse count", fp_cnt, 4);

        // Alternating enable only stretches time.
        apply_stimulus(1'b0, 1'b1);
        n = 0;
        for (int k = 0; k < 32; k++) begin
            x_prev = {x_hi, x_lo};
            apply_stimulus(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
            if (k % 2 == 0) begin
                n++;
                check_all(n, "alt");
            end else begin
                check_output("alt hold x", {28'd0, x_hi, x_lo}, {28'd0, x_prev});
                check_output("alt idle line_pulse", {31'd0, line_pulse}, 0);
                check_output("alt idle frame_pulse", {31'd0, frame_pulse}, 0);
            end
        end
        check_output("alt final x", {28'd0, x_hi, x_lo}, 0);
        check_output("alt final y", {29'd0, y_hi, y_lo}, 1);

        // Reset in the middle of both sync pulses.
        apply_stimulus(1'b0, 1'b1);
        for (int i = 1; i <= 91; i++) apply_stimulus(1'b1, 1'b1);
        check_all(91, "pre-abort");
        check_output("pre-abort hsync active", {31'd0, hsync}, 0);
        check_output("pre-abort vsync active", {31'd0, vsync}, 1);
        apply_stimulus(1'b0, 1'b1);
        check_all(0, "abort");
        check_output("abort line_pulse", {31'd0, line_pulse}, 0);
        check_output("abort frame_pulse", {31'd0, frame_pulse}, 0);
        apply_stimulus(1'b1, 1'b1);
        check_all(1, "release");

        // Disabled clocks hold every register.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0);
            check_all(1, "hold");
            check_output("hold line_pulse", {31'd0, line_pulse}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
